// File: rtl/sram_sync_controller.sv
// Synchronous SSRAM controller: registered IDLE/CMD/WAIT/ACK FSM with a req/ack handshake.
// Optional one-entry read buffer is enabled by defining SRAM_RDBUF_EN.
module sram_sync_controller #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 19,
   parameter logic [31:0] BASE_ADDR   = 32'h1004_0000,
   parameter logic [31:0] END_ADDR    = 32'h1017_FFFF,
   parameter int unsigned READ_LAT    = 2,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iReq,
   input  logic                iWriteEnable,
   input  logic [DATA_W/8-1:0] iByteEnable,
   input  logic [31:0]         iAddress,
   input  logic [DATA_W-1:0]   iWriteData,
   output logic                oHit,
   output logic                oAck,
   output logic [DATA_W-1:0]   oReadData,
   output logic                oBusy,
   inout  wire  [DATA_W-1:0]   SRAM_DQ,
   output logic [ADDR_W-1:0]   oSRAM_A,
   output logic [DATA_W/8-1:0] oSRAM_BE_N,
   output logic                oSRAM_ADSP_N,
   output logic                oSRAM_WE_N,
   output logic                oSRAM_OE_N,
   output logic                oSRAM_CLK,
   output logic                oSRAM_CE1_N,
   output logic                oSRAM_CE2,
   output logic                oSRAM_CE3_N,
   output logic                oSRAM_ADSC_N,
   output logic                oSRAM_ADV_N,
   output logic                oSRAM_GW_N
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {IDLE, CMD, WAIT, ACK} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                is_write_q, is_write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BE_W-1:0]     be_n_q, be_n_d;
   logic                adsp_n_q, adsp_n_d;
   logic                we_n_q, we_n_d;
   logic                oe_n_q, oe_n_d;
   logic                dq_oe_q, dq_oe_d;
   logic [DATA_W-1:0]   dq_out_q, dq_out_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ack_q, ack_d;

   logic [ADDR_W-1:0]   word_addr;
   logic                buf_hit;
   logic [DATA_W-1:0]   buf_rdata;

   assign oHit      = (iAddress >= BASE_ADDR) && (iAddress <= END_ADDR);
   assign word_addr = ADDR_W'((iAddress - BASE_ADDR) >> 2);

`ifdef SRAM_RDBUF_EN
   logic                buf_valid_q, buf_valid_d;
   logic [ADDR_W-1:0]   buf_tag_q, buf_tag_d;
   logic [DATA_W-1:0]   buf_data_q, buf_data_d;
   logic                rd_sample, wr_accept;

   assign rd_sample = (state_q == WAIT) && !is_write_q && (cnt_q == CNT_W'(READ_LAT - 1));
   assign wr_accept = (state_q == IDLE) && iReq && oHit && iWriteEnable;
   assign buf_hit   = buf_valid_q && (buf_tag_q == word_addr) && (&iByteEnable);
   assign buf_rdata = buf_data_q;

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_data_d  = buf_data_q;
      if (rd_sample) begin
         buf_valid_d = 1'b1;
         buf_tag_d   = addr_q;
         buf_data_d  = SRAM_DQ;
      end else if (wr_accept && (buf_tag_q == word_addr)) begin
         buf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         buf_data_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         buf_data_q  <= buf_data_d;
      end
   end
`else
   assign buf_hit   = 1'b0;
   assign buf_rdata = '0;
`endif

   // NOTE: every _d starts as its _q so no path through the case leaves a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_write_d = is_write_q;
      addr_d     = addr_q;
      be_n_d     = be_n_q;
      adsp_n_d   = adsp_n_q;
      we_n_d     = we_n_q;
      oe_n_d     = oe_n_q;
      dq_oe_d    = dq_oe_q;
      dq_out_d   = dq_out_q;
      rdata_d    = rdata_q;
      ack_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (iReq && oHit) begin
               is_write_d = iWriteEnable;
               addr_d     = word_addr;
               cnt_d      = '0;
               if (!iWriteEnable && buf_hit) begin
                  state_d = ACK;
                  ack_d   = 1'b1;
                  rdata_d = buf_rdata;
               end else begin
                  state_d  = CMD;
                  be_n_d   = ~iByteEnable;
                  adsp_n_d = 1'b0;
                  if (iWriteEnable) begin
                     we_n_d   = 1'b0;
                     dq_oe_d  = 1'b1;
                     dq_out_d = iWriteData;
                  end else begin
                     oe_n_d = 1'b0;
                  end
               end
            end
         end
         CMD: begin
            adsp_n_d = 1'b1;
            we_n_d   = 1'b1;
            dq_oe_d  = 1'b0;
            be_n_d   = '1;
            cnt_d    = '0;
            if (is_write_q && (WAIT_STATES == 0)) begin
               state_d = ACK;
               ack_d   = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (!is_write_q) begin
               if (cnt_q == CNT_W'(READ_LAT - 1)) begin
                  rdata_d = SRAM_DQ;
                  oe_n_d  = 1'b1;
                  state_d = ACK;
                  ack_d   = 1'b1;
               end
            end else if (cnt_q == CNT_W'(WAIT_STATES - 1)) begin
               state_d = ACK;
               ack_d   = 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_write_q <= 1'b0;
         addr_q     <= '0;
         be_n_q     <= '1;
         adsp_n_q   <= 1'b1;
         we_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         dq_oe_q    <= 1'b0;
         dq_out_q   <= '0;
         rdata_q    <= '0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_write_q <= is_write_d;
         addr_q     <= addr_d;
         be_n_q     <= be_n_d;
         adsp_n_q   <= adsp_n_d;
         we_n_q     <= we_n_d;
         oe_n_q     <= oe_n_d;
         dq_oe_q    <= dq_oe_d;
         dq_out_q   <= dq_out_d;
         rdata_q    <= rdata_d;
         ack_q      <= ack_d;
      end
   end

   assign SRAM_DQ      = dq_oe_q ? dq_out_q : 'z;
   assign oAck         = ack_q;
   assign oReadData    = rdata_q;
   assign oBusy        = (state_q != IDLE);
   assign oSRAM_A      = addr_q;
   assign oSRAM_BE_N   = be_n_q;
   assign oSRAM_ADSP_N = adsp_n_q;
   assign oSRAM_WE_N   = we_n_q;
   assign oSRAM_OE_N   = oe_n_q;
   assign oSRAM_CLK    = iCLK;
   assign oSRAM_CE1_N  = 1'b0;
   assign oSRAM_CE2    = 1'b1;
   assign oSRAM_CE3_N  = 1'b0;
   assign oSRAM_ADSC_N = 1'b1;
   assign oSRAM_ADV_N  = 1'b1;
   assign oSRAM_GW_N   = 1'b1;

endmodule

// File: tb/tb_sram_sync_controller.sv
// Directed bench: two controllers (WAIT_STATES 0 and 3, READ_LAT 2) each with a pipelined SSRAM model.
module tb_sram_sync_controller;

   localparam logic [31:0] BASE = 32'h1004_0000;
   localparam logic [31:0] LAST = 32'h1017_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req    [2];
   logic        we     [2];
   logic [3:0]  be     [2];
   logic [31:0] addr   [2];
   logic [31:0] wdata  [2];
   logic        hit    [2];
   logic        ack    [2];
   logic [31:0] rdata  [2];
   logic        busy   [2];
   logic [18:0] sram_a [2];
   logic [3:0]  be_n   [2];
   logic        adsp_n [2];
   logic        we_n   [2];
   logic        oe_n   [2];
   logic        sclk   [2];
   logic        ce1_n  [2];
   logic        ce2    [2];
   logic        ce3_n  [2];
   logic        adsc_n [2];
   logic        adv_n  [2];
   logic        gw_n   [2];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : u
      wire  [31:0] dq;
      logic [31:0] mem [1024];
      logic        pv0, pv1;
      logic [31:0] pd0, pd1;

      sram_sync_controller #(.READ_LAT(2), .WAIT_STATES(g == 0 ? 0 : 3)) dut (
         .iCLK(clk), .iRST_N(rst_n), .iReq(req[g]), .iWriteEnable(we[g]),
         .iByteEnable(be[g]), .iAddress(addr[g]), .iWriteData(wdata[g]),
         .oHit(hit[g]), .oAck(ack[g]), .oReadData(rdata[g]), .oBusy(busy[g]),
         .SRAM_DQ(dq), .oSRAM_A(sram_a[g]), .oSRAM_BE_N(be_n[g]),
         .oSRAM_ADSP_N(adsp_n[g]), .oSRAM_WE_N(we_n[g]), .oSRAM_OE_N(oe_n[g]),
         .oSRAM_CLK(sclk[g]), .oSRAM_CE1_N(ce1_n[g]), .oSRAM_CE2(ce2[g]),
         .oSRAM_CE3_N(ce3_n[g]), .oSRAM_ADSC_N(adsc_n[g]), .oSRAM_ADV_N(adv_n[g]),
         .oSRAM_GW_N(gw_n[g])
      );

      initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

      // Pipelined SSRAM: command captured on ADSP_N low, read data driven READ_LAT-1 cycles later.
      always @(posedge clk) begin
         pv0 <= !adsp_n[g] && we_n[g];
         pd0 <= mem[sram_a[g][9:0]];
         pv1 <= pv0;
         pd1 <= pd0;
         if (!adsp_n[g] && !we_n[g])
            for (int i = 0; i < 4; i++)
               if (!be_n[g][i]) mem[sram_a[g][9:0]][8*i +: 8] <= dq[8*i +: 8];
      end

      assign dq = (!oe_n[g] && pv1) ? pd1 : 32'hz;
   end

   // Called #1 after a posedge; returns #1 after the edge that ends oAck.
   task automatic access(input int g, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int ack_n, output logic [31:0] rd,
                         output int adsp_cnt, output int we_cnt, output logic [18:0] a_seen);
      ack_n = 0; rd = '0; adsp_cnt = 0; we_cnt = 0; a_seen = '0;
      req[g] = 1'b1; we[g] = w; addr[g] = a; be[g] = b; wdata[g] = d;
      for (int n = 1; n <= 30 && ack_n == 0; n++) begin
         @(posedge clk); @(negedge clk);
         if (!adsp_n[g]) begin adsp_cnt++; a_seen = sram_a[g]; end
         if (!we_n[g]) we_cnt++;
         if (ack[g]) begin ack_n = n; rd = rdata[g]; req[g] = 1'b0; end
      end
      req[g] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #12;
      tests++; if (ack[0] !== 1'b0)       begin fails++; $display("FAIL rst_ack: got %b want 0", ack[0]); end
      tests++; if (busy[0] !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b want 0", busy[0]); end
      tests++; if (rdata[0] !== 32'h0)    begin fails++; $display("FAIL rst_rdata: got %h want 0", rdata[0]); end
      tests++; if (adsp_n[0] !== 1'b1)    begin fails++; $display("FAIL rst_adsp_n: got %b want 1", adsp_n[0]); end
      tests++; if (we_n[0] !== 1'b1)      begin fails++; $display("FAIL rst_we_n: got %b want 1", we_n[0]); end
      tests++; if (oe_n[0] !== 1'b1)      begin fails++; $display("FAIL rst_oe_n: got %b want 1", oe_n[0]); end
      tests++; if (be_n[0] !== 4'hF)      begin fails++; $display("FAIL rst_be_n: got %h want f", be_n[0]); end
      tests++; if (sram_a[0] !== 19'h0)   begin fails++; $display("FAIL rst_a: got %h want 0", sram_a[0]); end
      tests++; if ({ce1_n[0], ce2[0], ce3_n[0], adsc_n[0], adv_n[0], gw_n[0]} !== 6'b010111)
         begin fails++; $display("FAIL tieoffs: got %b want 010111",
                                 {ce1_n[0], ce2[0], ce3_n[0], adsc_n[0], adv_n[0], gw_n[0]}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      int n, ac, wc; logic [31:0] rd; logic [18:0] a;
      access(0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, n, rd, ac, wc, a);
      tests++; if (n !== 2)      begin fails++; $display("FAIL wr_ack_cycle: got %0d want 2", n); end
      tests++; if (a !== 19'h4)  begin fails++; $display("FAIL wr_addr: got %h want 4", a); end
      tests++; if (ac !== 1)     begin fails++; $display("FAIL wr_adsp_cycles: got %0d want 1", ac); end
      tests++; if (wc !== 1)     begin fails++; $display("FAIL wr_we_cycles: got %0d want 1", wc); end
      access(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, n, rd, ac, wc, a);
      tests++; if (n !== 4)      begin fails++; $display("FAIL rd_ack_cycle: got %0d want 4", n); end
      tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h want deadbeef", rd); end
      tests++; if (wc !== 0)     begin fails++; $display("FAIL rd_we_cycles: got %0d want 0", wc); end
      tests++; if (ac !== 1)     begin fails++; $display("FAIL rd_adsp_cycles: got %0d want 1", ac); end
   endtask

   task automatic test_byte_lanes();
      int n, ac, wc; logic [31:0] rd; logic [18:0] a;
      access(0, 1'b1, BASE + 32'h10, 4'b0010, 32'h0000AB00, n, rd, ac, wc, a);
      tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rdata_held_on_write: got %h want deadbeef", rd); end
      access(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, n, rd, ac, wc, a);
      tests++; if (rd !== 32'hDEADABEF) begin fails++; $display("FAIL be_merge: got %h want deadabef", rd); end
      access(0, 1'b1, BASE + 32'h10, 4'h0, 32'hFFFFFFFF, n, rd, ac, wc, a);
      tests++; if (n !== 2)  begin fails++; $display("FAIL be0_ack_cycle: got %0d want 2", n); end
      access(0, 1'b0, BASE + 32'h13, 4'hF, 32'h0, n, rd, ac, wc, a);
      tests++; if (a !== 19'h4)         begin fails++; $display("FAIL low_bits_addr: got %h want 4", a); end
      tests++; if (rd !== 32'hDEADABEF) begin fails++; $display("FAIL be0_no_write: got %h want deadabef", rd); end
   endtask

   task automatic test_decode();
      int n, ac, wc, acks; logic [31:0] rd; logic [18:0] a;
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = LAST + 32'd4; be[0] = 4'hF; wdata[0] = 32'h5555AAAA;
      ac = 0; acks = 0;
      #1;
      tests++; if (hit[0] !== 1'b0) begin fails++; $display("FAIL hit_above_end: got %b want 0", hit[0]); end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (!adsp_n[0]) ac++;
         if (ack[0]) acks++;
      end
      tests++; if (ac !== 0)   begin fails++; $display("FAIL miss_adsp: got %0d want 0", ac); end
      tests++; if (acks !== 0) begin fails++; $display("FAIL miss_ack: got %0d want 0", acks); end
      addr[0] = BASE - 32'd4; #1;
      tests++; if (hit[0] !== 1'b0) begin fails++; $display("FAIL hit_below_base: got %b want 0", hit[0]); end
      addr[0] = BASE; #1;
      tests++; if (hit[0] !== 1'b1) begin fails++; $display("FAIL hit_base: got %b want 1", hit[0]); end
      req[0] = 1'b0;
      @(posedge clk); #1;
      access(0, 1'b1, LAST, 4'hF, 32'h12345678, n, rd, ac, wc, a);
      tests++; if (a !== 19'h4FFFF) begin fails++; $display("FAIL end_addr: got %h want 4ffff", a); end
      tests++; if (n !== 2)         begin fails++; $display("FAIL end_ack_cycle: got %0d want 2", n); end
      access(0, 1'b0, LAST, 4'hF, 32'h0, n, rd, ac, wc, a);
      tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL end_data: got %h want 12345678", rd); end
   endtask

   task automatic test_wait_states();
      int n, ac, wc; logic [31:0] rd; logic [18:0] a;
      access(1, 1'b1, BASE + 32'h20, 4'hF, 32'hCAFEF00D, n, rd, ac, wc, a);
      tests++; if (n !== 5)  begin fails++; $display("FAIL ws3_ack_cycle: got %0d want 5", n); end
      tests++; if (wc !== 1) begin fails++; $display("FAIL ws3_we_cycles: got %0d want 1", wc); end
      tests++; if (busy[1] !== 1'b0) begin fails++; $display("FAIL gap_busy: got %b want 0", busy[1]); end
      access(1, 1'b1, BASE + 32'h24, 4'hF, 32'h0BADF00D, n, rd, ac, wc, a);
      tests++; if (n !== 5)     begin fails++; $display("FAIL b2b_ack_cycle: got %0d want 5", n); end
      tests++; if (a !== 19'h9) begin fails++; $display("FAIL b2b_addr: got %h want 9", a); end
      access(1, 1'b0, BASE + 32'h20, 4'hF, 32'h0, n, rd, ac, wc, a);
      tests++; if (n !== 4)             begin fails++; $display("FAIL ws3_rd_cycle: got %0d want 4", n); end
      tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL ws3_rd0: got %h want cafef00d", rd); end
      access(1, 1'b0, BASE + 32'h24, 4'hF, 32'h0, n, rd, ac, wc, a);
      tests++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL ws3_rd1: got %h want 0badf00d", rd); end
   endtask

   task automatic test_reset_mid_read();
      int acks = 0;
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'h10; be[0] = 4'hF;
      @(posedge clk); @(posedge clk); @(negedge clk);
      tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b want 1", busy[0]); end
      rst_n = 1'b0; req[0] = 1'b0; #1;
      tests++; if (busy[0] !== 1'b0)   begin fails++; $display("FAIL mid_state_idle: got %b want 0", busy[0]); end
      tests++; if ({adsp_n[0], we_n[0], oe_n[0]} !== 3'b111)
         begin fails++; $display("FAIL mid_strobes: got %b want 111", {adsp_n[0], we_n[0], oe_n[0]}); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack[0]) acks++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack[0]) acks++;
      end
      tests++; if (acks !== 0) begin fails++; $display("FAIL mid_no_ack: got %0d want 0", acks); end
      @(posedge clk); #1;
   endtask

`ifdef SRAM_RDBUF_EN
   task automatic test_rdbuf();
      int n, ac, wc; logic [31:0] rd; logic [18:0] a;
      access(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, n, rd, ac, wc, a);
      tests++; if (n !== 4) begin fails++; $display("FAIL buf_first_cycle: got %0d want 4", n); end
      access(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, n, rd, ac, wc, a);
      tests++; if (n !== 1)  begin fails++; $display("FAIL buf_hit_cycle: got %0d want 1", n); end
      tests++; if (ac !== 0) begin fails++; $display("FAIL buf_hit_adsp: got %0d want 0", ac); end
      tests++; if (rd !== 32'hDEADABEF) begin fails++; $display("FAIL buf_hit_data: got %h want deadabef", rd); end
      access(0, 1'b1, BASE + 32'h10, 4'hF, 32'h600DCAFE, n, rd, ac, wc, a);
      access(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, n, rd, ac, wc, a);
      tests++; if (ac !== 1) begin fails++; $display("FAIL buf_inval_adsp: got %0d want 1", ac); end
      tests++; if (rd !== 32'h600DCAFE) begin fails++; $display("FAIL buf_inval_data: got %h want 600dcafe", rd); end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
         req[g] = 1'b0; we[g] = 1'b0; be[g] = 4'h0; addr[g] = 32'h0; wdata[g] = 32'h0;
      end
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_decode();
      test_wait_states();
      test_reset_mid_read();
`ifdef SRAM_RDBUF_EN
      test_rdbuf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
